fetch_stage: RTL and testbench

Instruction fetch stage directly upstream of `instruction_decoder`. It holds the PC, issues in-order word reads to instruction memory with up to two requests in flight, and buffers responses in a 2-entry FIFO. It presents one instruction per valid/ready handshake to the decoder, whose `en` is driven by `dec_valid`. It also handles PC redirects from branch/trap logic and discards stale in-flight responses.

---
 rtl/fetch_stage.sv | 149 ++++++++++++++
 tb/tb_fetch_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the PC, keeps up to two word reads in flight to
// instruction memory and hands buffered instructions to the decoder.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instruction_code,
    output logic [31:0] dec_pc,
    output logic        dec_fetch_err
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  out_cnt_q, out_cnt_d;
    logic [1:0]  kill_cnt_q, kill_cnt_d;
    logic [1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic [31:0] h_data_q, h_data_d, h_pc_q, h_pc_d;
    logic        h_err_q, h_err_d;
    logic [31:0] s_data_q, s_data_d, s_pc_q, s_pc_d;
    logic        s_err_q, s_err_d;

    logic req_fire, kill_hit, enq, deq;

    assign imem_req_valid = (state_q == RUN) && !redirect_valid &&
                            (({1'b0, out_cnt_q} + {1'b0, fifo_cnt_q}) < 3'd2);
    assign imem_req_addr  = fetch_pc_q;

    // The head entry drives the decoder directly; it is cleared whenever the FIFO empties.
    assign dec_valid            = (fifo_cnt_q != 2'd0);
    assign dec_instruction_code = h_data_q;
    assign dec_pc               = h_pc_q;
    assign dec_fetch_err        = h_err_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign kill_hit = imem_resp_valid && (kill_cnt_q != 2'd0);
    assign enq      = imem_resp_valid && !kill_hit && (state_q != HALT) && !redirect_valid;
    assign deq      = dec_valid && dec_ready && !redirect_valid;

    always_comb begin
        state_d    = state_q;
        out_cnt_d  = out_cnt_q + {1'b0, req_fire} - {1'b0, imem_resp_valid};
        kill_cnt_d = kill_cnt_q - {1'b0, kill_hit};
        fifo_cnt_d = fifo_cnt_q;
        fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        resp_pc_d  = (imem_resp_valid && !kill_hit) ? resp_pc_q + 32'd4 : resp_pc_q;
        h_data_d   = h_data_q;
        h_pc_d     = h_pc_q;
        h_err_d    = h_err_q;
        s_data_d   = s_data_q;
        s_pc_d     = s_pc_q;
        s_err_d    = s_err_q;

        if (state_q == IDLE)
            state_d = RUN;
        if (enq && imem_resp_err)
            state_d = HALT;

        case ({enq, deq})
            2'b10: begin
                if (fifo_cnt_q == 2'd0) begin
                    h_data_d = imem_resp_data;
                    h_pc_d   = resp_pc_q;
                    h_err_d  = imem_resp_err;
                end else begin
                    s_data_d = imem_resp_data;
                    s_pc_d   = resp_pc_q;
                    s_err_d  = imem_resp_err;
                end
                fifo_cnt_d = fifo_cnt_q + 2'd1;
            end
            2'b01: begin
                if (fifo_cnt_q == 2'd2) begin
                    h_data_d = s_data_q;
                    h_pc_d   = s_pc_q;
                    h_err_d  = s_err_q;
                end else begin
                    h_data_d = 32'h0;
                    h_pc_d   = 32'h0;
                    h_err_d  = 1'b0;
                end
                fifo_cnt_d = fifo_cnt_q - 2'd1;
            end
            2'b11: begin
                h_data_d = imem_resp_data;
                h_pc_d   = resp_pc_q;
                h_err_d  = imem_resp_err;
            end
            default: ;
        endcase

        // Redirect wins: every response still in flight after this cycle becomes stale.
        if (redirect_valid) begin
            state_d    = RUN;
            kill_cnt_d = out_cnt_q - {1'b0, imem_resp_valid};
            fifo_cnt_d = 2'd0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            resp_pc_d  = {redirect_pc[31:2], 2'b00};
            h_data_d   = 32'h0;
            h_pc_d     = 32'h0;
            h_err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            out_cnt_q  <= 2'd0;
            kill_cnt_q <= 2'd0;
            fifo_cnt_q <= 2'd0;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            h_data_q   <= 32'h0;
            h_pc_q     <= 32'h0;
            h_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_cnt_q  <= out_cnt_d;
            kill_cnt_q <= kill_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            h_data_q   <= h_data_d;
            h_pc_q     <= h_pc_d;
            h_err_q    <= h_err_d;
        end
    end

    // Second slot is only read once fifo_cnt says it holds a valid entry.
    always_ff @(posedge clk) begin
        s_data_q <= s_data_d;
        s_pc_q   <= s_pc_d;
        s_err_q  <= s_err_d;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small in-order instruction memory model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instruction_code;
    logic [31:0] dec_pc;
    logic        dec_fetch_err;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
    } dl_t;

    dl_t         dlv[$];
    logic [31:0] acc_log[$];
    logic [31:0] pend[$];
    logic [31:0] err_addr = 32'hDEAD_BEE0;
    logic        mem_hold = 1'b0;
    int          total = 0;
    int          bad = 0;

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .imem_req_valid       (imem_req_valid),
        .imem_req_addr        (imem_req_addr),
        .imem_req_ready       (imem_req_ready),
        .imem_resp_valid      (imem_resp_valid),
        .imem_resp_data       (imem_resp_data),
        .imem_resp_err        (imem_resp_err),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc),
        .dec_valid            (dec_valid),
        .dec_ready            (dec_ready),
        .dec_instruction_code (dec_instruction_code),
        .dec_pc               (dec_pc),
        .dec_fetch_err        (dec_fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_dlv(input int n, input string tag);
        int k = 0;
        while (dlv.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(dlv.size() >= n), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] pc);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rv"},   32'(imem_req_valid), 32'd0);
        chk({tag, "_addr"}, imem_req_addr, 32'h0000_0100);
        chk({tag, "_dv"},   32'(dec_valid), 32'd0);
        chk({tag, "_code"}, dec_instruction_code, 32'h0);
        chk({tag, "_pc"},   dec_pc, 32'h0);
        chk({tag, "_err"},  32'(dec_fetch_err), 32'd0);
    endtask

    // Memory: accepts at the edge, answers in the following cycle, holds 0x200..0x207 on request.
    initial begin
        logic [31:0] a;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        imem_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && imem_req_valid && imem_req_ready) begin
                pend.push_back(imem_req_addr);
                acc_log.push_back(imem_req_addr);
            end
            @(posedge clk); #1;
            if (!rst_n) pend.delete();
            if (rst_n && pend.size() > 0 &&
                !(mem_hold && pend[0] >= 32'h200 && pend[0] < 32'h208)) begin
                a = pend.pop_front();
                imem_resp_valid = 1'b1;
                imem_resp_data  = mw(a);
                imem_resp_err   = (a == err_addr);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'h0;
                imem_resp_err   = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && dec_valid && dec_ready && !redirect_valid)
                dlv.push_back('{pc: dec_pc, data: dec_instruction_code, err: dec_fetch_err});
        end
    end

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b1;

        // Reset state and startup timing
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("startup_c1_rv", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        chk("startup_c2_rv", 32'(imem_req_valid), 32'd1);
        chk("startup_c2_addr", imem_req_addr, 32'h0000_0100);
        wait_dlv(3, "run_wait");
        chk("run_pc0", dlv[0].pc, 32'h100);
        chk("run_pc1", dlv[1].pc, 32'h104);
        chk("run_pc2", dlv[2].pc, 32'h108);
        chk("run_data0", dlv[0].data, 32'h1257_6520);
        chk("run_data1", dlv[1].data, mw(32'h104));
        chk("run_data2", dlv[2].data, mw(32'h108));
        chk("run_req1", acc_log[1], 32'h104);
        chk("run_req2", acc_log[2], 32'h108);

        // Backpressure from a fresh reset
        @(posedge clk); #1;
        rst_n = 1'b0;
        dec_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        acc_log.delete();
        dlv.delete();
        repeat (7) @(negedge clk);
        chk("bp_rv", 32'(imem_req_valid), 32'd0);
        chk("bp_dv", 32'(dec_valid), 32'd1);
        chk("bp_head", dec_pc, 32'h100);
        chk("bp_reqs", 32'(acc_log.size()), 32'd2);
        @(posedge clk); #1;
        dec_ready = 1'b1;
        wait_dlv(2, "bp_wait");
        chk("bp_pc0", dlv[0].pc, 32'h100);
        chk("bp_pc1", dlv[1].pc, 32'h104);
        chk("bp_data1", dlv[1].data, mw(32'h104));

        // Two stale requests killed by a redirect
        @(negedge clk);
        mem_hold = 1'b1;
        redirect(32'h200);
        repeat (4) @(negedge clk);
        chk("kill_rv", 32'(imem_req_valid), 32'd0);
        chk("kill_req_a", acc_log[acc_log.size() - 2], 32'h200);
        chk("kill_req_b", acc_log[acc_log.size() - 1], 32'h204);
        dlv.delete();
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h402;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        mem_hold = 1'b0;
        @(negedge clk);
        chk("redir_dv", 32'(dec_valid), 32'd0);
        wait_dlv(1, "kill_wait");
        chk("kill_pc", dlv[0].pc, 32'h400);
        chk("kill_data", dlv[0].data, mw(32'h400));

        // Error response halts fetch until a redirect
        err_addr = 32'h300;
        dlv.delete();
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        acc_log.delete();
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        wait_dlv(1, "err_wait");
        chk("err_pc", dlv[0].pc, 32'h300);
        chk("err_flag", 32'(dlv[0].err), 32'd1);
        repeat (6) @(negedge clk);
        chk("halt_rv", 32'(imem_req_valid), 32'd0);
        chk("halt_dlv", 32'(dlv.size()), 32'd1);
        chk("halt_reqs", 32'(acc_log.size()), 32'd2);
        err_addr = 32'hDEAD_BEE0;
        redirect(32'h0);
        wait_dlv(2, "resume_wait");
        chk("resume_pc", dlv[1].pc, 32'h0);
        chk("resume_err", 32'(dlv[1].err), 32'd0);

        // PC wrap at the top of the address space
        dlv.delete();
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        acc_log.delete();
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        wait_dlv(2, "wrap_wait");
        chk("wrap_req0", acc_log[0], 32'hFFFF_FFFC);
        chk("wrap_req1", acc_log[1], 32'h0);
        chk("wrap_pc0", dlv[0].pc, 32'hFFFF_FFFC);
        chk("wrap_pc1", dlv[1].pc, 32'h0);
        chk("wrap_data1", dlv[1].data, mw(32'h0));

        // Asynchronous reset with a valid head and one request outstanding
        @(posedge clk); #1;
        dec_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("pre_rst_dv", 32'(dec_valid), 32'd1);
        chk("pre_rst_pc", dec_pc, 32'h500);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        repeat (2) @(posedge clk);
        #2;
        dec_ready = 1'b1;
        acc_log.delete();
        dlv.delete();
        rst_n = 1'b1;
        wait_dlv(1, "rerun_wait");
        chk("rerun_req", acc_log[0], 32'h100);
        chk("rerun_pc", dlv[0].pc, 32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
